inv_clarke: RTL and testbench

Inverse Clarke transform for the motor-control datapath. It takes a stationary-frame vector (alpha, beta) and produces three-phase quantities a, b, c as signed fixed-point values. It is a 2-stage pipeline with valid/ready handshakes on both sides. It sits between the inverse Park / modulation-index stage and the PWM duty generator, and is the return path of the forward Clarke block.

---
 rtl/inv_clarke.sv | 140 ++++++++++++++
 tb/tb_inv_clarke.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_clarke.sv
// rtl/inv_clarke.sv - two-stage inverse Clarke transform (alpha/beta to a/b/c) with valid/ready flow control
module inv_clarke #(
    parameter int D_WIDTH = 18,
    parameter int Q_BITS  = 15
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic [D_WIDTH-1:0] alpha,
    input  logic [D_WIDTH-1:0] beta,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [D_WIDTH-1:0] a,
    output logic [D_WIDTH-1:0] b,
    output logic [D_WIDTH-1:0] c,
    output logic               sat,
    output logic               out_valid,
    input  logic               out_ready
);

    // Full-precision product width and the widened b/c width used before clipping.
    localparam int PW = D_WIDTH + Q_BITS + 1;
    localparam int WW = D_WIDTH + 2;

    // sqrt(3)/2 in Q_BITS fractional bits, rounded to nearest.
    localparam int K_INT = $rtoi(0.8660254037844386 * (2.0 ** Q_BITS) + 0.5);
    localparam logic signed [PW-1:0] K_EXT  = PW'(K_INT);
    localparam logic signed [PW-1:0] RND    = PW'(2 ** (Q_BITS - 1));
    localparam logic signed [WW-1:0] SAT_HI = {3'b000, {(D_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] SAT_LO = {3'b111, {(D_WIDTH-1){1'b0}}};

    logic               s1_valid_q, s1_valid_d;
    logic [D_WIDTH-1:0] s1_alpha_q, s1_alpha_d;
    logic [D_WIDTH-1:0] s1_p_q,     s1_p_d;
    logic [D_WIDTH-1:0] a_q, a_d;
    logic [D_WIDTH-1:0] b_q, b_d;
    logic [D_WIDTH-1:0] c_q, c_d;
    logic               sat_q, sat_d;
    logic               out_valid_q, out_valid_d;

    logic s2_adv;
    logic s1_adv;

    logic signed [PW-1:0] beta_ext;
    logic signed [PW-1:0] prod;
    logic signed [WW-1:0] half_w;
    logic signed [WW-1:0] p_w;
    logic signed [WW-1:0] b_w;
    logic signed [WW-1:0] c_w;

    // Pipeline advance conditions; a stage may load when it is empty or its successor drains.
    always_comb begin
        s2_adv   = !out_valid_q | out_ready;
        s1_adv   = !s1_valid_q | s2_adv;
        in_ready = s1_adv;
    end

    // Stage 1: scale beta by K and round half-up, capture alpha alongside it.
    always_comb begin
        beta_ext   = {{(PW-D_WIDTH){beta[D_WIDTH-1]}}, beta};
        prod       = beta_ext * K_EXT;
        s1_valid_d = s1_valid_q;
        s1_alpha_d = s1_alpha_q;
        s1_p_d     = s1_p_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_alpha_d = alpha;
                s1_p_d     = D_WIDTH'((prod + RND) >>> Q_BITS);
            end
        end
    end

    // Stage 2: form b and c two bits wider than the ports, then clip and flag clipping.
    always_comb begin
        half_w      = {{3{s1_alpha_q[D_WIDTH-1]}}, s1_alpha_q[D_WIDTH-1:1]};
        p_w         = {{2{s1_p_q[D_WIDTH-1]}}, s1_p_q};
        b_w         = p_w - half_w;
        c_w         = -half_w - p_w;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                a_d   = s1_alpha_q;
                sat_d = 1'b0;
                if (b_w > SAT_HI) begin
                    b_d   = SAT_HI[D_WIDTH-1:0];
                    sat_d = 1'b1;
                end else if (b_w < SAT_LO) begin
                    b_d   = SAT_LO[D_WIDTH-1:0];
                    sat_d = 1'b1;
                end else begin
                    b_d = b_w[D_WIDTH-1:0];
                end
                if (c_w > SAT_HI) begin
                    c_d   = SAT_HI[D_WIDTH-1:0];
                    sat_d = 1'b1;
                end else if (c_w < SAT_LO) begin
                    c_d   = SAT_LO[D_WIDTH-1:0];
                    sat_d = 1'b1;
                end else begin
                    c_d = c_w[D_WIDTH-1:0];
                end
            end
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_valid_q  <= 1'b0;
            s1_alpha_q  <= '0;
            s1_p_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_alpha_q  <= s1_alpha_d;
            s1_p_q      <= s1_p_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign c         = c_q;
    assign sat       = sat_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_inv_clarke.sv
// tb/tb_inv_clarke.sv - self-checking bench for inv_clarke against an arithmetic reference model
module tb_inv_clarke;

    localparam int     DW = 18;
    localparam longint K  = 28378;

    logic          clk       = 1'b0;
    logic          rstb      = 1'b0;
    logic [DW-1:0] alpha     = '0;
    logic [DW-1:0] beta      = '0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] c;
    logic          sat;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    inv_clarke #(.D_WIDTH(18), .Q_BITS(15)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .alpha     (alpha),
        .beta      (beta),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    function automatic longint sx(input logic [DW-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint floor_div(input longint n, input longint d);
        longint q;
        q = n / d;
        if ((n % d) != 0 && n < 0) q = q - 1;
        return q;
    endfunction

    function automatic void ref_model(input longint al, input longint be,
                                      output longint ea, output longint eb,
                                      output longint ec, output bit es);
        longint h, p, bw, cw;
        h  = floor_div(al, 2);
        p  = floor_div(be * K + 16384, 32768);
        bw = p - h;
        cw = -h - p;
        es = 1'b0;
        if (bw > 131071)  begin bw = 131071;  es = 1'b1; end
        if (bw < -131072) begin bw = -131072; es = 1'b1; end
        if (cw > 131071)  begin cw = 131071;  es = 1'b1; end
        if (cw < -131072) begin cw = -131072; es = 1'b1; end
        ea = al;
        eb = bw;
        ec = cw;
    endfunction

    function automatic longint rnd_val();
        logic [DW-1:0] r;
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return -131072;
        if (sel == 1) return 131071;
        r = DW'($urandom);
        return sx(r);
    endfunction

    task automatic one_sample(input longint al, input longint be,
                              output longint oa, output longint ob,
                              output longint oc, output bit os, output bit got);
        @(negedge clk);
        alpha     = al[DW-1:0];
        beta      = be[DW-1:0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        got = 1'b0;
        oa = 0; ob = 0; oc = 0; os = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            if (out_valid) begin
                got = 1'b1;
                oa = sx(a); ob = sx(b); oc = sx(c); os = sat;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        n_cmp++;
        if (a !== '0 || b !== '0 || c !== '0 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL reset_data: a=%0d b=%0d c=%0d sat=%b expected 0", sx(a), sx(b), sx(c), sat);
        end
        rstb = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic;
        @(negedge clk);
        alpha     = 18'd32768;
        beta      = '0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL latency_early: out_valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || sx(a) !== 64'sd32768 || sx(b) !== -64'sd16384 ||
            sx(c) !== -64'sd16384 || sat !== 1'b0) begin
            n_err++;
            $display("FAIL basic: v=%b a=%0d b=%0d c=%0d sat=%b expected 1 32768 -16384 -16384 0",
                     out_valid, sx(a), sx(b), sx(c), sat);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_pulse: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_values;
        longint oa, ob, oc, ea, eb, ec, al, be;
        bit os, es, got;
        one_sample(0, 32768, oa, ob, oc, os, got);
        n_cmp++;
        if (!got || oa !== 0 || ob !== 28378 || oc !== -28378 || os !== 1'b0) begin
            n_err++;
            $display("FAIL beta_only: got=%b a=%0d b=%0d c=%0d sat=%b expected 0 28378 -28378 0",
                     got, oa, ob, oc, os);
        end
        one_sample(-3, 0, oa, ob, oc, os, got);
        n_cmp++;
        if (!got || oa !== -3 || ob !== 2 || oc !== 2 || os !== 1'b0) begin
            n_err++;
            $display("FAIL floor_shift: got=%b a=%0d b=%0d c=%0d sat=%b expected -3 2 2 0",
                     got, oa, ob, oc, os);
        end
        for (int i = 0; i < 8; i++) begin
            al = rnd_val();
            be = rnd_val();
            ref_model(al, be, ea, eb, ec, es);
            one_sample(al, be, oa, ob, oc, os, got);
            n_cmp++;
            if (!got || oa !== ea || ob !== eb || oc !== ec || os !== es) begin
                n_err++;
                $display("FAIL rand_single %0d: in=(%0d,%0d) got=%b a/b/c/sat=%0d/%0d/%0d/%b expected %0d/%0d/%0d/%b",
                         i, al, be, got, oa, ob, oc, os, ea, eb, ec, es);
            end
        end
    endtask

    task automatic test_saturation;
        longint oa, ob, oc;
        bit os, got;
        one_sample(-131072, 131071, oa, ob, oc, os, got);
        n_cmp++;
        if (!got || oa !== -131072 || ob !== 131071 || oc !== -47975 || os !== 1'b1) begin
            n_err++;
            $display("FAIL sat_b_high: got=%b a=%0d b=%0d c=%0d sat=%b expected -131072 131071 -47975 1",
                     got, oa, ob, oc, os);
        end
        one_sample(131071, 131071, oa, ob, oc, os, got);
        n_cmp++;
        if (!got || oa !== 131071 || ob !== 47976 || oc !== -131072 || os !== 1'b1) begin
            n_err++;
            $display("FAIL sat_c_low: got=%b a=%0d b=%0d c=%0d sat=%b expected 131071 47976 -131072 1",
                     got, oa, ob, oc, os);
        end
        one_sample(131071, -131072, oa, ob, oc, os, got);
        n_cmp++;
        if (!got || oa !== 131071 || ob !== -131072 || oc !== 47977 || os !== 1'b1) begin
            n_err++;
            $display("FAIL sat_b_low: got=%b a=%0d b=%0d c=%0d sat=%b expected 131071 -131072 47977 1",
                     got, oa, ob, oc, os);
        end
    endtask

    task automatic test_back_to_back;
        longint al[3], be[3], ea[3], eb[3], ec[3];
        bit es[3];
        for (int i = 0; i < 3; i++) begin
            al[i] = rnd_val();
            be[i] = rnd_val();
            ref_model(al[i], be[i], ea[i], eb[i], ec[i], es[i]);
        end
        @(negedge clk);
        out_ready = 1'b0;
        alpha = al[0][DW-1:0]; beta = be[0][DW-1:0]; in_valid = 1'b1;
        @(negedge clk);
        alpha = al[1][DW-1:0]; beta = be[1][DW-1:0];
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_second_accept: in_ready=%b expected 1", in_ready);
        end
        @(negedge clk);
        alpha = al[2][DW-1:0]; beta = be[2][DW-1:0];
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || sx(a) !== ea[0] || sx(b) !== eb[0] ||
            sx(c) !== ec[0] || sat !== es[0]) begin
            n_err++;
            $display("FAIL bp_full: rdy=%b v=%b a/b/c/sat=%0d/%0d/%0d/%b expected 0 1 %0d/%0d/%0d/%b",
                     in_ready, out_valid, sx(a), sx(b), sx(c), sat, ea[0], eb[0], ec[0], es[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || sx(a) !== ea[0] || sx(b) !== eb[0] ||
            sx(c) !== ec[0] || sat !== es[0]) begin
            n_err++;
            $display("FAIL bp_hold: rdy=%b v=%b a/b/c/sat=%0d/%0d/%0d/%b expected 0 1 %0d/%0d/%0d/%b",
                     in_ready, out_valid, sx(a), sx(b), sx(c), sat, ea[0], eb[0], ec[0], es[0]);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release_ready: in_ready=%b expected 1", in_ready);
        end
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b1 || sx(a) !== ea[i] || sx(b) !== eb[i] || sx(c) !== ec[i] || sat !== es[i]) begin
                n_err++;
                $display("FAIL bp_drain %0d: v=%b a/b/c/sat=%0d/%0d/%0d/%b expected 1 %0d/%0d/%0d/%b",
                         i, out_valid, sx(a), sx(b), sx(c), sat, ea[i], eb[i], ec[i], es[i]);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_no_extra: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_stream;
        longint q_a[$], q_b[$], q_c[$];
        bit     q_s[$];
        longint cur_al = 0, cur_be = 0, ea, eb, ec, xa, xb, xc;
        bit     es, xs, offering = 1'b0, stall_prev = 1'b0;
        logic [DW-1:0] pa = '0, pb = '0, pc = '0;
        logic   ps = 1'b0;
        int n_in = 0, n_out = 0, cyc = 0;
        while ((n_in < 10000 || q_a.size() != 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (!offering && n_in < 10000 && $urandom_range(0, 3) != 0) begin
                cur_al   = rnd_val();
                cur_be   = rnd_val();
                offering = 1'b1;
            end
            in_valid  = offering;
            alpha     = cur_al[DW-1:0];
            beta      = cur_be[DW-1:0];
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (stall_prev) begin
                n_cmp++;
                if (out_valid !== 1'b1 || a !== pa || b !== pb || c !== pc || sat !== ps) begin
                    n_err++;
                    $display("FAIL stream_stall_hold cyc %0d: v=%b a/b/c=%0d/%0d/%0d expected held %0d/%0d/%0d",
                             cyc, out_valid, sx(a), sx(b), sx(c), sx(pa), sx(pb), sx(pc));
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q_a.size() == 0) begin
                    n_err++;
                    $display("FAIL stream_extra cyc %0d: output with no pending sample, a=%0d", cyc, sx(a));
                end else begin
                    xa = q_a.pop_front(); xb = q_b.pop_front();
                    xc = q_c.pop_front(); xs = q_s.pop_front();
                    n_out++;
                    if (sx(a) !== xa || sx(b) !== xb || sx(c) !== xc || sat !== xs) begin
                        n_err++;
                        $display("FAIL stream_data #%0d: a/b/c/sat=%0d/%0d/%0d/%b expected %0d/%0d/%0d/%b",
                                 n_out, sx(a), sx(b), sx(c), sat, xa, xb, xc, xs);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            pa = a; pb = b; pc = c; ps = sat;
            if (offering && in_ready) begin
                ref_model(cur_al, cur_be, ea, eb, ec, es);
                q_a.push_back(ea); q_b.push_back(eb); q_c.push_back(ec); q_s.push_back(es);
                n_in++;
                offering = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (n_in != 10000 || n_out != n_in || q_a.size() != 0) begin
            n_err++;
            $display("FAIL stream_count: in=%0d out=%0d pending=%0d expected 10000 each, 0 pending",
                     n_in, n_out, q_a.size());
        end
    endtask

    task automatic test_reset_mid;
        longint oa, ob, oc, ea, eb, ec, al, be;
        bit os, es, got, seen;
        @(negedge clk);
        out_ready = 1'b0;
        alpha = 18'd1000; beta = 18'd2000; in_valid = 1'b1;
        @(negedge clk);
        alpha = 18'd3000; beta = 18'd4000;
        @(negedge clk);
        in_valid = 1'b0;
        rstb = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || a !== '0 || b !== '0 || c !== '0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset: v=%b a/b/c=%0d/%0d/%0d rdy=%b expected 0 0/0/0 1",
                     out_valid, sx(a), sx(b), sx(c), in_ready);
        end
        @(negedge clk);
        rstb = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++;
            $display("FAIL mid_reset_ghost: out_valid=1 seen after reset, expected 0");
        end
        al = rnd_val();
        be = rnd_val();
        ref_model(al, be, ea, eb, ec, es);
        one_sample(al, be, oa, ob, oc, os, got);
        n_cmp++;
        if (!got || oa !== ea || ob !== eb || oc !== ec || os !== es) begin
            n_err++;
            $display("FAIL mid_reset_new: got=%b a/b/c/sat=%0d/%0d/%0d/%b expected %0d/%0d/%0d/%b",
                     got, oa, ob, oc, os, ea, eb, ec, es);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_values();
        test_saturation();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
